// File: rtl/mul_iter_if.sv
// Request/response val/rdy bundle for the iterative multiplier.
// The master drives operands and accepts products; the slave is the multiplier.
interface mul_iter_if #(
  parameter int p_width = 4
);
  logic               req_val;
  logic               req_rdy;
  logic [p_width-1:0] req_msg_a;
  logic [p_width-1:0] req_msg_b;
  logic               resp_val;
  logic               resp_rdy;
  logic [p_width-1:0] resp_msg;

  modport master (
    output req_val, req_msg_a, req_msg_b, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport slave (
    input  req_val, req_msg_a, req_msg_b, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: p_width fixed iterations per product,
// low p_width bits returned over val/rdy, one transaction in flight.
module mul_iter #(
  parameter int p_width = 4
) (
  input  logic      clk,
  input  logic      reset,
  mul_iter_if.slave io
);

  localparam int cnt_w = (p_width > 2) ? $clog2(p_width) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(p_width - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [p_width-1:0] a_q, a_d;
  logic [p_width-1:0] b_q, b_d;
  logic [p_width-1:0] acc_q, acc_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  logic               resp_val_q, resp_val_d;
  logic               req_rdy;
  logic               req_fire;
  logic               load;

  // Ready follows resp_rdy in DONE so a new pair can enter as the product leaves.
  assign req_rdy  = reset & ((state_q == IDLE) | ((state_q == DONE) & io.resp_rdy));
  assign req_fire = io.req_val & req_rdy;

  assign io.req_rdy  = req_rdy;
  assign io.resp_val = resp_val_q;
  assign io.resp_msg = acc_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_fire) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (b_q[0]) begin
          acc_d = acc_q + a_q;
        end
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + cnt_w'(1);
        if (cnt_q == cnt_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.resp_rdy) begin
          if (req_fire) begin
            load    = 1'b1;
            state_d = CALC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      a_d   = io.req_msg_a;
      b_d   = io.req_msg_b;
      acc_d = '0;
      cnt_d = '0;
    end

    resp_val_d = (state_d == DONE);
  end

  // resp_val is registered as a decode of the next state, so it never sees req_val.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      resp_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      resp_val_q <= resp_val_d;
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed cases plus randomized operand pairs
// with random response stalls, checked against (a*b) mod 2^P and fixed latency.
module tb_mul_iter;

  localparam int P       = 4;
  localparam int LATENCY = P + 1;
  localparam int MOD     = 1 << P;

  logic clk;
  logic reset;
  int   checks;
  int   passes;

  mul_iter_if #(.p_width(P)) bus ();

  mul_iter #(.p_width(P)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One full transaction: accept, fixed latency, optional stall, hand-off.
  task automatic applyStimulus(input logic [P-1:0] a, input logic [P-1:0] b,
                               input int stall);
    int waited;
    logic [P-1:0] expected;
    expected = P'((int'(a) * int'(b)) % MOD);
    @(negedge clk);
    bus.req_val   = 1'b1;
    bus.req_msg_a = a;
    bus.req_msg_b = b;
    bus.resp_rdy  = (stall == 0);
    waited = 0;
    #1;
    while (!bus.req_rdy && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("accept", bus.req_rdy, 1);
    if (!bus.req_rdy) begin
      bus.req_val = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_val   = 1'b0;
    bus.req_msg_a = P'($urandom);
    bus.req_msg_b = P'($urandom);
    for (int n = 1; n <= LATENCY; n++) begin
      @(negedge clk);
      #1;
      if (n < LATENCY) begin
        checkOutput("calc_no_val", bus.resp_val, 0);
        checkOutput("calc_rdy_low", bus.req_rdy, 0);
      end else begin
        checkOutput("latency_val", bus.resp_val, 1);
        checkOutput("product", bus.resp_msg, expected);
        checkOutput("done_rdy", bus.req_rdy, (stall == 0) ? 1 : 0);
      end
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      checkOutput("stall_val", bus.resp_val, 1);
      checkOutput("stall_msg", bus.resp_msg, expected);
      checkOutput("stall_rdy", bus.req_rdy, 0);
    end
    if (stall > 0) begin
      bus.resp_rdy = 1'b1;
      #1;
      checkOutput("release_rdy", bus.req_rdy, 1);
    end
    @(negedge clk);
    #1;
    checkOutput("idle_val", bus.resp_val, 0);
    checkOutput("idle_rdy", bus.req_rdy, 1);
  endtask

  initial begin
    logic [P-1:0] pa [3];
    logic [P-1:0] pb [3];
    int           resp_cyc [$];
    logic [P-1:0] resp_msg_q [$];
    int           idx;
    int           viol;
    int           seen_val;
    logic         started;
    logic         fire;

    checks = 0;
    passes = 0;
    bus.req_val   = 1'b0;
    bus.req_msg_a = '0;
    bus.req_msg_b = '0;
    bus.resp_rdy  = 1'b0;
    reset         = 1'b0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      bus.req_val = 1'b1;
      checkOutput("rst_req_rdy", bus.req_rdy, 0);
      checkOutput("rst_resp_val", bus.resp_val, 0);
      checkOutput("rst_resp_msg", bus.resp_msg, 0);
    end
    bus.req_val = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("post_rst_rdy", bus.req_rdy, 1);
    checkOutput("post_rst_val", bus.resp_val, 0);

    // Basic product and truncation cases
    applyStimulus(4'd3, 4'd5, 0);
    applyStimulus(4'd5, 4'd7, 0);
    applyStimulus(4'd15, 4'd15, 0);
    applyStimulus(4'd0, 4'd9, 0);
    applyStimulus(4'd9, 4'd1, 0);

    // Back-to-back stream with req_val held high
    pa[0] = 4'd2; pb[0] = 4'd3;
    pa[1] = 4'd4; pb[1] = 4'd4;
    pa[2] = 4'd7; pb[2] = 4'd2;
    idx = 0;
    viol = 0;
    started = 1'b0;
    @(negedge clk);
    bus.req_val   = 1'b1;
    bus.req_msg_a = pa[0];
    bus.req_msg_b = pb[0];
    bus.resp_rdy  = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (bus.resp_val && bus.resp_rdy) begin
        resp_cyc.push_back(cyc);
        resp_msg_q.push_back(bus.resp_msg);
      end
      if (started && resp_cyc.size() < 3 && (bus.req_rdy !== bus.resp_val)) viol++;
      fire = bus.req_val & bus.req_rdy;
      if (fire) started = 1'b1;
      @(posedge clk);
      #1;
      if (fire) begin
        idx++;
        if (idx < 3) begin
          bus.req_msg_a = pa[idx];
          bus.req_msg_b = pb[idx];
        end else begin
          bus.req_val = 1'b0;
        end
      end
      @(negedge clk);
    end
    checkOutput("b2b_count", resp_cyc.size(), 3);
    checkOutput("b2b_rdy_only_done", viol, 0);
    if (resp_cyc.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput("b2b_product", resp_msg_q[k], (int'(pa[k]) * int'(pb[k])) % MOD);
      end
      checkOutput("b2b_spacing1", resp_cyc[1] - resp_cyc[0], LATENCY);
      checkOutput("b2b_spacing2", resp_cyc[2] - resp_cyc[1], LATENCY);
    end

    // Backpressure for ten cycles
    applyStimulus(4'd6, 4'd2, 10);

    // Reset asserted two cycles into a calculation
    @(negedge clk);
    bus.req_val   = 1'b1;
    bus.req_msg_a = 4'd3;
    bus.req_msg_b = 4'd3;
    bus.resp_rdy  = 1'b1;
    #1;
    checkOutput("mid_accept", bus.req_rdy, 1);
    @(posedge clk);
    #1;
    bus.req_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_val", bus.resp_val, 0);
    checkOutput("mid_rst_rdy", bus.req_rdy, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_post_rdy", bus.req_rdy, 1);
    seen_val = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (bus.resp_val) seen_val++;
    end
    checkOutput("mid_no_resp", seen_val, 0);
    applyStimulus(4'd2, 4'd2, 0);

    // Randomized pairs with random response stalls
    for (int t = 0; t < 20; t++) begin
      applyStimulus(P'($urandom), P'($urandom), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
